// File: rtl/vga_timing_sequencer.sv
// VGA raster timing generator: a three-state sequencer (idle/run/drain) that walks
// h/v position counters and produces registered, skew-free sync/enable/strobe outputs.
module vga_timing_sequencer #(
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int COUNTER_SIZE    = 11,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic                    control_clock,
   input  logic                    reset,
   input  logic                    run,
   output logic                    busy,
   output logic [COUNTER_SIZE-1:0] pixel_x,
   output logic [COUNTER_SIZE-1:0] pixel_y,
   output logic                    display_enabled,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    line_start,
   output logic                    frame_start,
   output logic [1:0]              o_dbg_state
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [COUNTER_SIZE-1:0] H_LAST     = COUNTER_SIZE'(H_TOTAL - 1);
   localparam logic [COUNTER_SIZE-1:0] V_LAST     = COUNTER_SIZE'(V_TOTAL - 1);
   localparam logic [COUNTER_SIZE-1:0] H_VIS      = COUNTER_SIZE'(H_VISIBLE);
   localparam logic [COUNTER_SIZE-1:0] V_VIS      = COUNTER_SIZE'(V_VISIBLE);
   localparam logic [COUNTER_SIZE-1:0] HS_START   = COUNTER_SIZE'(H_VISIBLE + H_FRONT);
   localparam logic [COUNTER_SIZE-1:0] HS_END     = COUNTER_SIZE'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [COUNTER_SIZE-1:0] VS_START   = COUNTER_SIZE'(V_VISIBLE + V_FRONT);
   localparam logic [COUNTER_SIZE-1:0] VS_END     = COUNTER_SIZE'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [COUNTER_SIZE-1:0] CNT_ONE    = COUNTER_SIZE'(1);

   localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic SYNC_OFF = ~SYNC_ON;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]              r_state;
   logic [COUNTER_SIZE-1:0] r_h;
   logic [COUNTER_SIZE-1:0] r_v;
   logic                    r_busy;
   logic                    r_de;
   logic                    r_hsync;
   logic                    r_vsync;
   logic                    r_line_start;
   logic                    r_frame_start;

   logic [1:0]              w_state_n;
   logic [COUNTER_SIZE-1:0] w_h_n;
   logic [COUNTER_SIZE-1:0] w_v_n;
   logic                    w_h_last;
   logic                    w_v_last;
   logic                    w_busy_n;
   logic                    w_hs_on_n;
   logic                    w_vs_on_n;

   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);

   // Next position and state; in RUN/DRAIN the counters always advance, and the only
   // place a draining sequencer may stop is the final pixel of the frame.
   always_comb begin
      w_state_n = r_state;
      w_h_n     = r_h;
      w_v_n     = r_v;
      case (r_state)
         ST_IDLE: begin
            w_h_n = '0;
            w_v_n = '0;
            if (run) w_state_n = ST_RUN;
         end
         ST_RUN, ST_DRAIN: begin
            if (w_h_last) begin
               w_h_n = '0;
               w_v_n = w_v_last ? '0 : (r_v + CNT_ONE);
            end else begin
               w_h_n = r_h + CNT_ONE;
            end
            if (run)
               w_state_n = ST_RUN;
            else if (r_state == ST_DRAIN && w_h_last && w_v_last)
               w_state_n = ST_IDLE;
            else
               w_state_n = ST_DRAIN;
         end
         default: begin
            w_state_n = ST_IDLE;
            w_h_n     = '0;
            w_v_n     = '0;
         end
      endcase
   end

   // Decode outputs from the next position so they land in the same register stage.
   assign w_busy_n  = (w_state_n != ST_IDLE);
   assign w_hs_on_n = w_busy_n && (w_h_n >= HS_START) && (w_h_n < HS_END);
   assign w_vs_on_n = w_busy_n && (w_v_n >= VS_START) && (w_v_n < VS_END);

   always_ff @(posedge control_clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_h           <= '0;
         r_v           <= '0;
         r_busy        <= 1'b0;
         r_de          <= 1'b0;
         r_hsync       <= SYNC_OFF;
         r_vsync       <= SYNC_OFF;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_h           <= w_h_n;
         r_v           <= w_v_n;
         r_busy        <= w_busy_n;
         r_de          <= w_busy_n && (w_h_n < H_VIS) && (w_v_n < V_VIS);
         r_hsync       <= w_hs_on_n ? SYNC_ON : SYNC_OFF;
         r_vsync       <= w_vs_on_n ? SYNC_ON : SYNC_OFF;
         r_line_start  <= w_busy_n && (w_h_n == '0);
         r_frame_start <= w_busy_n && (w_h_n == '0) && (w_v_n == '0);
      end
   end

   assign busy            = r_busy;
   assign pixel_x         = r_h;
   assign pixel_y         = r_v;
   assign display_enabled = r_de;
   assign hsync           = r_hsync;
   assign vsync           = r_vsync;
   assign line_start      = r_line_start;
   assign frame_start     = r_frame_start;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Randomized scoreboard bench: two small-geometry instances (active-low and active-high sync)
// checked every cycle against a linear frame-position reference model.
module tb_vga_timing_sequencer;

   localparam int CS = 11;
   localparam int NCYC = 20000;

   logic clk = 1'b0;
   logic rst;
   logic run;

   always #5 clk = ~clk;

   // Instance A: 10/2/3/2 x 5/1/2/2, active-low sync. Instance B: 4/1/2/1 x 3/1/1/1, active-high.
   logic          busy_a, de_a, hs_a, vs_a, ls_a, fs_a;
   logic [CS-1:0] x_a, y_a;
   logic [1:0]    st_a;
   logic          busy_b, de_b, hs_b, vs_b, ls_b, fs_b;
   logic [CS-1:0] x_b, y_b;
   logic [1:0]    st_b;

   vga_timing_sequencer #(
      .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .COUNTER_SIZE(CS), .SYNC_ACTIVE_LOW(1)
   ) dut_a (
      .control_clock(clk), .reset(rst), .run(run), .busy(busy_a),
      .pixel_x(x_a), .pixel_y(y_a), .display_enabled(de_a),
      .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a),
      .o_dbg_state(st_a)
   );

   vga_timing_sequencer #(
      .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .COUNTER_SIZE(CS), .SYNC_ACTIVE_LOW(0)
   ) dut_b (
      .control_clock(clk), .reset(rst), .run(run), .busy(busy_b),
      .pixel_x(x_b), .pixel_y(y_b), .display_enabled(de_b),
      .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b),
      .o_dbg_state(st_b)
   );

   logic [27:0] act_a, act_b;
   assign act_a = {busy_a, x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a};
   assign act_b = {busy_b, x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b};

   logic [27:0] exp_qa[$];
   logic [27:0] exp_qb[$];
   int tests = 0;
   int fails = 0;

   // Reference model: a frame is one linear walk p = 0 .. H_TOTAL*V_TOTAL-1.
   bit m_act[2];
   bit m_drain[2];
   int m_p[2];

   function automatic int geo(int sel, int idx);
      int ga[9] = '{10, 2, 3, 2, 5, 1, 2, 2, 1};
      int gb[9] = '{4, 1, 2, 1, 3, 1, 1, 1, 0};
      return (sel == 0) ? ga[idx] : gb[idx];
   endfunction

   function automatic int h_total(int sel);
      return geo(sel, 0) + geo(sel, 1) + geo(sel, 2) + geo(sel, 3);
   endfunction

   function automatic int frame_len(int sel);
      return h_total(sel) * (geo(sel, 4) + geo(sel, 5) + geo(sel, 6) + geo(sel, 7));
   endfunction

   function automatic logic [27:0] exp_vec(int sel, bit act, int p);
      int h, v, hsb, vsb;
      bit hs_on, vs_on, de, hs_lvl, vs_lvl;
      logic [CS-1:0] hx, vx;
      h = act ? (p % h_total(sel)) : 0;
      v = act ? (p / h_total(sel)) : 0;
      hsb = geo(sel, 0) + geo(sel, 1);
      vsb = geo(sel, 4) + geo(sel, 5);
      hs_on = act && (h >= hsb) && (h < hsb + geo(sel, 2));
      vs_on = act && (v >= vsb) && (v < vsb + geo(sel, 6));
      de = act && (h < geo(sel, 0)) && (v < geo(sel, 4));
      hs_lvl = (geo(sel, 8) == 1) ? !hs_on : hs_on;
      vs_lvl = (geo(sel, 8) == 1) ? !vs_on : vs_on;
      hx = CS'(h);
      vx = CS'(v);
      return {act, hx, vx, de, hs_lvl, vs_lvl, act && (h == 0), act && (h == 0) && (v == 0)};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_act[s] = 1'b0;
         m_drain[s] = 1'b0;
         m_p[s] = 0;
      end
   endtask

   task automatic model_step(input int sel, input bit r);
      if (!m_act[sel]) begin
         if (r) begin
            m_act[sel] = 1'b1;
            m_p[sel] = 0;
            m_drain[sel] = 1'b0;
         end
      end else if (m_p[sel] == frame_len(sel) - 1 && m_drain[sel] && !r) begin
         m_act[sel] = 1'b0;
         m_p[sel] = 0;
      end else begin
         m_p[sel] = (m_p[sel] + 1) % frame_len(sel);
         m_drain[sel] = !r;
      end
   endtask

   task automatic push_expected();
      exp_qa.push_back(exp_vec(0, m_act[0], m_p[0]));
      exp_qb.push_back(exp_vec(1, m_act[1], m_p[1]));
   endtask

   task automatic check_now(input string name, input logic [27:0] got, input logic [27:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   // Monitor: outputs are stable mid-cycle; pop one expectation per DUT per cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_qa.size() > 0) check_now("dut_a_cycle", act_a, exp_qa.pop_front());
         if (exp_qb.size() > 0) check_now("dut_b_cycle", act_b, exp_qb.pop_front());
      end
   end

   // Driver: sample-and-step the model just after each edge, then drive the next run level.
   initial begin
      int seg;
      seg = 0;
      rst = 1'b1;
      run = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_now("reset_a", act_a, exp_vec(0, 1'b0, 0));
      check_now("reset_b", act_b, exp_vec(1, 1'b0, 0));
      rst = 1'b0;
      run = 1'b1;
      seg = 400;
      push_expected();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         if (rst) begin
            model_reset();
            rst = 1'b0;
         end else begin
            model_step(0, run);
            model_step(1, run);
            if (cyc == 5000 || $urandom_range(0, 599) == 0) begin
               rst = 1'b1;
               model_reset();
               #1;
               check_now("async_reset_a", act_a, exp_vec(0, 1'b0, 0));
               check_now("async_reset_b", act_b, exp_vec(1, 1'b0, 0));
            end
         end
         push_expected();
         if (seg == 0) begin
            run = ($urandom_range(0, 3) != 0);
            seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(20, 400);
         end else begin
            seg--;
         end
      end
      @(negedge clk);
      #1;
      tests++;
      if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
         fails++;
         $display("FAIL queue_drain: got %0d/%0d left expected 0/0", exp_qa.size(), exp_qb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_sequencer.md
VGA_TIMING_SEQUENCER -- requirements
Module: vga_timing_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BACK, 48, horizontal back porch in clocks.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- COUNTER_SIZE, 11, width of both position counters.
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync are driven low when asserted.

REQ-002 Ports (name, direction, width, meaning), one per line:
- control_clock, in, 1, the single clock, rising-edge.
- reset, in, 1, asynchronous, active-high.
- run, in, 1, level request to generate frames.
- busy, out, 1, sequencer is not IDLE.
- pixel_x, out, COUNTER_SIZE, horizontal count h.
- pixel_y, out, COUNTER_SIZE, vertical count v.
- display_enabled, out, 1, h and v are both in the visible region.
- hsync, out, 1, horizontal sync at the SYNC_ACTIVE_LOW polarity.
- vsync, out, 1, vertical sync at the SYNC_ACTIVE_LOW polarity.
- line_start, out, 1, one-cycle pulse at h==0.
- frame_start, out, 1, one-cycle pulse at h==0 and v==0.

Function
REQ-003 Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default); both SHALL be less than 2^COUNTER_SIZE.
REQ-004 The FSM SHALL have exactly three states:
- IDLE: counters held at 0, all outputs inactive.
- RUN: generating frames.
- DRAIN: run has dropped; the current frame is completing.
REQ-005 IDLE -> RUN SHALL occur on the first rising edge where run==1; the first RUN cycle SHALL present h=0, v=0.
REQ-006 In RUN and DRAIN, h SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0.
REQ-007 v SHALL increment only on the cycle where h==H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0.
REQ-008 RUN -> DRAIN SHALL occur on any edge where run==0; counting continues unchanged.
REQ-009 DRAIN -> RUN SHALL occur if run==1 is sampled before the end of the frame; no counter disturbance is allowed.
REQ-010 At the frame end, on the edge where h==H_TOTAL-1 and v==V_TOTAL-1:
- DRAIN -> IDLE if run==0, with counters cleared to 0.
- DRAIN -> RUN if run==1, with counters wrapping to 0.
A frame SHALL never be truncated.
REQ-011 display_enabled SHALL be 1 iff busy and h<H_VISIBLE and v<V_VISIBLE.
REQ-012 hsync SHALL be asserted iff busy and H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
REQ-013 vsync SHALL be asserted iff busy and V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC; vsync is aligned to h==0 line boundaries.
REQ-014 Sync level SHALL be 0 when asserted if SYNC_ACTIVE_LOW==1, and 1 when asserted otherwise; deasserted level is the inverse, including in IDLE and reset.
REQ-015 line_start SHALL be 1 iff busy and h==0.
REQ-016 frame_start SHALL be 1 iff busy and h==0 and v==0.
REQ-017 All outputs SHALL be registered and SHALL be mutually consistent with pixel_x/pixel_y in the same cycle, with zero skew between them.
REQ-018 pixel_x and pixel_y SHALL equal h and v; both SHALL be 0 in IDLE.
REQ-019 No counter SHALL ever present a value of H_TOTAL or V_TOTAL or larger, including across state changes.

Reset
REQ-020 When reset==1, the block SHALL immediately, without waiting for a clock edge:
- enter IDLE;
- clear h and v to 0;
- set busy, display_enabled, line_start and frame_start to 0;
- drive hsync and vsync to their deasserted level.
REQ-021 Reset asserted mid-frame SHALL abort the frame.
REQ-022 After reset deasserts, the block SHALL restart only per REQ-005.

Verification
REQ-023 Start-up, default parameters: run=1 held from reset release.
- First RUN cycle: frame_start=1, pixel_x=0, pixel_y=0, display_enabled=1.
- Next frame_start follows exactly 420000 clocks later.
REQ-024 Horizontal timing: over one line, display_enabled is high for h 0..639 and hsync is low for h 656..751.
- The line period is 800 clocks.
- line_start pulses once per line.
REQ-025 Vertical timing: vsync is low for exactly lines 490..491 (1600 clocks).
- vsync asserts on the same cycle as line_start at v=490.
- display_enabled is never 1 for v>=480.
REQ-026 Drain: drop run at h=100, v=200.
- busy stays 1 until after h=799, v=524.
- The block then enters IDLE with counters 0 and hsync=vsync=1.
- Re-asserting run at v=300 during DRAIN causes no gap and no restart.
REQ-027 Async reset: assert reset at h=700, v=491, away from a clock edge.
- Outputs go to reset values before the next edge.
- With run=1 after release, the block restarts at h=0, v=0 with frame_start=1.
REQ-028 Parameter check: with SYNC_ACTIVE_LOW=0 and H_* = 4/1/2/1, V_* = 3/1/1/1:
- H_TOTAL is 8 and V_TOTAL is 6.
- hsync is high only for h=5..6.
- vsync is high only for v=4.
